// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one shift level (2^k) is resolved per register stage,
// with a valid/ready handshake and a global stall on output backpressure.
module pipelined_barrel_shifter #(
    parameter  int WIDTH = 16,
    localparam int LOG_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num,
    input  logic [LOG_W-1:0] amt,
    input  logic             lr,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] shifted_num,
    output logic             zero
);

    typedef enum logic [1:0] {
        OP_LOGIC  = 2'b00,
        OP_ARITH  = 2'b01,
        OP_ROTATE = 2'b10,
        OP_BYPASS = 2'b11
    } op_t;

    // Everything a beat needs to finish its shift travels alongside the data.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [LOG_W-1:0] amt;
        op_t              kind;
        logic             dir;
        logic             sign;
    } beat_t;

    logic [LOG_W-1:0] vld;
    beat_t            stg [LOG_W];
    beat_t            in_beat;
    logic             advance;

    // Single shift/rotate by a fixed distance; sh is a constant per stage.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0] d,
        input int               sh,
        input op_t              kind,
        input logic             dir,
        input logic             sgn
    );
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] res;
        fill = (kind == OP_ARITH && sgn) ? ~({WIDTH{1'b1}} >> sh) : '0;
        unique case (kind)
            OP_BYPASS: res = d;
            OP_ROTATE: res = dir ? ((d << sh) | (d >> (WIDTH - sh)))
                                 : ((d >> sh) | (d << (WIDTH - sh)));
            default:   res = dir ? (d << sh) : ((d >> sh) | fill);
        endcase
        return res;
    endfunction

    function automatic beat_t stage_fn(input beat_t b, input int k);
        beat_t r;
        r = b;
        if (b.amt[k]) begin
            r.data = shift_by(b.data, 1 << k, b.kind, b.dir, b.sign);
        end
        return r;
    endfunction

    always_comb begin
        in_beat      = '0;
        in_beat.data = num;
        in_beat.amt  = amt;
        in_beat.kind = op_t'(op);
        in_beat.dir  = lr;
        in_beat.sign = num[WIDTH-1];
    end

    // The whole pipe moves or holds together; bubbles are carried, not squeezed.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its predecessor's pre-edge value; blocking here would collapse the pipe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld <= '0;
            // NOTE: stage data is reset too, so shifted_num reads 0 (and zero
            // reads 1) straight out of reset instead of stale contents.
            for (int k = 0; k < LOG_W; k++) begin
                stg[k] <= '0;
            end
        end else if (advance) begin
            vld    <= {vld[LOG_W-2:0], in_valid};
            stg[0] <= stage_fn(in_beat, 0);
            for (int k = 1; k < LOG_W; k++) begin
                stg[k] <= stage_fn(stg[k-1], k);
            end
        end
    end

    assign out_valid   = vld[LOG_W-1];
    assign shifted_num = stg[LOG_W-1].data;
    assign zero        = (shifted_num == '0);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at WIDTH 8, 16 and 32, with a
// scoreboard of expected results and a bit-level reference shifter.
module tb_pipelined_barrel_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic        in_valid_v  [3];
    logic        lr_v        [3];
    logic        out_ready_v [3];
    logic [1:0]  op_v        [3];
    logic [5:0]  amt_v       [3];
    logic [63:0] num_v       [3];
    logic [63:0] drv_exp     [3];
    logic [2:0]  ov, ir, zr;
    logic [7:0]  res8;
    logic [15:0] res16;
    logic [31:0] res32;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] exp;
        int          cyc;
    } exp_t;
    exp_t sb [3][$];

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_barrel_shifter #(.WIDTH(8)) dut8 (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid_v[0]), .in_ready(ir[0]),
        .num(num_v[0][7:0]), .amt(amt_v[0][2:0]), .lr(lr_v[0]), .op(op_v[0]),
        .out_valid(ov[0]), .out_ready(out_ready_v[0]),
        .shifted_num(res8), .zero(zr[0])
    );

    pipelined_barrel_shifter #(.WIDTH(16)) dut16 (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid_v[1]), .in_ready(ir[1]),
        .num(num_v[1][15:0]), .amt(amt_v[1][3:0]), .lr(lr_v[1]), .op(op_v[1]),
        .out_valid(ov[1]), .out_ready(out_ready_v[1]),
        .shifted_num(res16), .zero(zr[1])
    );

    pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
        .clk(clk), .n_rst(n_rst),
        .in_valid(in_valid_v[2]), .in_ready(ir[2]),
        .num(num_v[2][31:0]), .amt(amt_v[2][4:0]), .lr(lr_v[2]), .op(op_v[2]),
        .out_valid(ov[2]), .out_ready(out_ready_v[2]),
        .shifted_num(res32), .zero(zr[2])
    );

    function automatic int width_of(input int idx);
        return (idx == 0) ? 8 : (idx == 1) ? 16 : 32;
    endfunction

    function automatic int lw_of(input int idx);
        return (idx == 0) ? 3 : (idx == 1) ? 4 : 5;
    endfunction

    function automatic logic [63:0] res_of(input int idx);
        case (idx)
            0:       return {56'd0, res8};
            1:       return {48'd0, res16};
            default: return {32'd0, res32};
        endcase
    endfunction

    // Reference: each output bit is looked up at its source position.
    function automatic logic [63:0] ref_shift(input logic [63:0] n, input int w,
                                              input int a, input logic l,
                                              input logic [1:0] o);
        logic [63:0] r;
        int src;
        r = '0;
        if (o == 2'b11) return n;
        for (int i = 0; i < w; i++) begin
            src = l ? i - a : i + a;
            if (src >= 0 && src < w)   r[i] = n[src];
            else if (o == 2'b10)       r[i] = n[l ? src + w : src - w];
            else if (o == 2'b01 && !l) r[i] = n[w-1];
            else                       r[i] = 1'b0;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_hand(input int idx, input logic [63:0] n, input int a,
                              input logic l, input logic [1:0] o, input logic [63:0] e);
        in_valid_v[idx] = 1'b1;
        num_v[idx]      = n;
        amt_v[idx]      = 6'(a);
        lr_v[idx]       = l;
        op_v[idx]       = o;
        drv_exp[idx]    = e;
    endtask

    task automatic drive_model(input int idx, input logic [63:0] n, input int a,
                               input logic l, input logic [1:0] o);
        logic [63:0] m;
        m = (64'd1 << width_of(idx)) - 64'd1;
        drive_hand(idx, n & m, a, l, o, ref_shift(n & m, width_of(idx), a, l, o));
    endtask

    task automatic idle(input int idx);
        in_valid_v[idx] = 1'b0;
    endtask

    // One clock cycle: score any consumed result, record any accepted beat.
    // Entered and left 1 time unit after a rising edge.
    task automatic step(input int idx, input bit lat_chk, output bit acc);
        exp_t e;
        int   w;
        w   = width_of(idx);
        acc = 1'b0;
        #2;
        if (ov[idx] && out_ready_v[idx]) begin
            if (sb[idx].size() == 0) begin
                check($sformatf("w%0d unexpected result", w), 64'(ov[idx]), 64'd0);
            end else begin
                e = sb[idx].pop_front();
                check($sformatf("w%0d data", w), res_of(idx), e.exp);
                check($sformatf("w%0d zero", w), 64'(zr[idx]), 64'(e.exp == 64'd0));
                if (lat_chk)
                    check($sformatf("w%0d latency", w), 64'(cyc - e.cyc), 64'(lw_of(idx)));
            end
        end
        if (in_valid_v[idx] && ir[idx]) begin
            sb[idx].push_back('{drv_exp[idx], cyc});
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int idx, input bit lat_chk);
        bit acc;
        idle(idx);
        for (int i = 0; i < 60 && sb[idx].size() > 0; i++) step(idx, lat_chk, acc);
        check($sformatf("w%0d drained", width_of(idx)), 64'(sb[idx].size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          acc;
        int          b;
        int          stall;
        logic [63:0] n;

        for (int i = 0; i < 3; i++) begin
            in_valid_v[i]  = 1'b0;
            out_ready_v[i] = 1'b1;
            lr_v[i]        = 1'b0;
            op_v[i]        = 2'b00;
            amt_v[i]       = '0;
            num_v[i]       = '0;
            drv_exp[i]     = '0;
        end
        n_rst = 1'b0;
        #3;
        check("reset out_valid", 64'(ov[1]), 64'd0);
        check("reset shifted_num", 64'(res16), 64'd0);
        check("reset zero", 64'(zr[1]), 64'd1);
        check("reset in_ready", 64'(ir[1]), 64'd1);
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Logical left, single beat: result after exactly 4 cycles.
        drive_hand(1, 64'h00F1, 4, 1'b1, 2'b00, 64'h0F10);
        step(1, 1'b1, acc);
        check("tp1 accepted", 64'(acc), 64'd1);
        drain(1, 1'b1);

        // Arithmetic right, negative and positive operands.
        drive_hand(1, 64'h8001, 3, 1'b0, 2'b01, 64'hF000);
        step(1, 1'b1, acc);
        drive_hand(1, 64'h7FF0, 4, 1'b0, 2'b01, 64'h07FF);
        step(1, 1'b1, acc);
        drain(1, 1'b1);

        // Four back-to-back beats: rotate right, rotate left, bypass, shift to zero.
        drive_hand(1, 64'h1234, 4, 1'b0, 2'b10, 64'h4123);
        step(1, 1'b1, acc);
        check("b2b accept 0", 64'(acc), 64'd1);
        drive_hand(1, 64'h8001, 1, 1'b1, 2'b10, 64'h0003);
        step(1, 1'b1, acc);
        check("b2b accept 1", 64'(acc), 64'd1);
        drive_hand(1, 64'hBEEF, 7, 1'b0, 2'b11, 64'hBEEF);
        step(1, 1'b1, acc);
        check("b2b accept 2", 64'(acc), 64'd1);
        drive_hand(1, 64'h0001, 1, 1'b0, 2'b00, 64'h0000);
        step(1, 1'b1, acc);
        check("b2b accept 3", 64'(acc), 64'd1);
        drain(1, 1'b1);

        // Backpressure: six beats 1<<b, stall the output 3 cycles on first result.
        b     = 0;
        stall = -1;
        for (int c = 0; c < 60 && (b < 6 || sb[1].size() > 0); c++) begin
            if (stall < 0 && ov[1]) stall = 3;
            out_ready_v[1] = !(stall > 0);
            if (b < 6) drive_hand(1, 64'd1, b, 1'b1, 2'b00, 64'd1 << b);
            else       idle(1);
            if (stall > 0) begin
                #1;
                check("stall in_ready", 64'(ir[1]), 64'd0);
                check("stall hold", 64'(res16), 64'd1);
                stall--;
            end
            step(1, 1'b0, acc);
            if (acc) b++;
        end
        check("bp beats sent", 64'(b), 64'd6);
        check("bp stall seen", 64'(stall), 64'd0);
        out_ready_v[1] = 1'b1;
        drain(1, 1'b0);

        // Reset with one result presented and three beats in flight.
        for (int i = 0; i < 4; i++) begin
            drive_hand(1, 64'h00F0 | 64'(i), 1, 1'b1, 2'b00, (64'h00F0 | 64'(i)) << 1);
            step(1, 1'b1, acc);
        end
        idle(1);
        #1;
        check("pre-reset out_valid", 64'(ov[1]), 64'd1);
        check("pre-reset data", 64'(res16), 64'h01E0);
        n_rst = 1'b0;
        #1;
        check("mid reset out_valid", 64'(ov[1]), 64'd0);
        check("mid reset shifted_num", 64'(res16), 64'd0);
        check("mid reset zero", 64'(zr[1]), 64'd1);
        check("mid reset in_ready", 64'(ir[1]), 64'd1);
        sb[1].delete();
        @(posedge clk);
        #2 n_rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            check("post-reset idle", 64'(ov[1]), 64'd0);
            step(1, 1'b1, acc);
        end
        drive_hand(1, 64'hA5A5, 8, 1'b0, 2'b10, 64'hA5A5);
        step(1, 1'b1, acc);
        drain(1, 1'b1);

        // Every op/lr/amt combination at WIDTH 8 and 32, streamed back-to-back.
        for (int k = 0; k < 2; k++) begin
            int idx;
            idx = (k == 0) ? 0 : 2;
            for (int o = 0; o < 4; o++) begin
                for (int l = 0; l < 2; l++) begin
                    for (int a = 0; a < width_of(idx); a++) begin
                        n = {$urandom, $urandom};
                        drive_model(idx, n, a, l[0], o[1:0]);
                        step(idx, 1'b1, acc);
                    end
                end
            end
            drain(idx, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the 16-bit combinational barrel shifter. It supports logical shift, arithmetic shift, rotate and bypass in both directions. One shift level is resolved per pipeline stage, with a valid/ready handshake on both sides, so it can sit between streaming datapath blocks rather than drive the LEDs directly. Its default configuration (16-bit) matches the board switch/LED width.

Parameters:
WIDTH, 16, data width in bits; power of two, 4..64
LOG_W, $clog2(WIDTH), derived (localparam); shift-amount width and pipeline depth

Ports:
clk  input  1  rising-edge clock
n_rst  input  1  asynchronous active-low reset
in_valid  input  1  input beat present
in_ready  output  1  block accepts input this cycle
num  input  WIDTH  operand
amt  input  LOG_W  shift/rotate amount, 0..WIDTH-1
lr  input  1  direction: 1 = left, 0 = right
op  input  2  00 logical, 01 arithmetic, 10 rotate, 11 bypass
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
shifted_num  output  WIDTH  result
zero  output  1  high when shifted_num == 0 (qualified by out_valid)

Behaviour:
- Reset (n_rst low, asynchronous): all stage valid bits = 0, all stage data = 0. Outputs: out_valid = 0, shifted_num = 0, zero = 1, in_ready = 1.
- Pipeline structure:
  - LOG_W register stages.
  - Stage k (k = 0..LOG_W-1) applies a shift/rotate of 2^k when amt[k] = 1; otherwise it passes data through.
  - op, lr, the remaining amt bits and the original sign bit num[WIDTH-1] travel with the data.
- Global advance: advance = !out_valid || out_ready; in_ready = advance.
  - When advance = 1, every stage loads from its predecessor and stage 0 loads the input.
  - When advance = 0, all stages hold.
  - Bubbles are not collapsed.
- Input handshake: a beat is accepted when in_valid && in_ready. When in_valid = 0 on an advance cycle, a bubble (valid = 0) enters stage 0.
- Latency: exactly LOG_W cycles from acceptance to out_valid with out_ready held high (4 cycles at WIDTH = 16). Throughput is 1 beat/cycle.
- Output handshake: shifted_num and zero are stable while out_valid && !out_ready. A result is consumed on out_valid && out_ready.
- Per-op arithmetic:
  - Logical: vacated bits are filled with 0.
  - Arithmetic right: vacated bits are filled with the original num[WIDTH-1].
  - Arithmetic left: identical to logical left.
  - Rotate: bits shifted out re-enter at the opposite end.
  - Bypass: shifted_num = num regardless of amt and lr.
- amt = 0 gives shifted_num = num for every op. amt is always < WIDTH, so there is no over-shift case.
- zero is computed combinationally from the output stage register.
- Simultaneous accept and emit: allowed in the same cycle (full-throughput streaming).
- Reset mid-operation: every in-flight beat is discarded, nothing is emitted afterwards, and the first post-reset result arrives LOG_W cycles after the next accepted beat.
- No other state: no counters beyond the stage valid bits, no error outputs.

Test Plan:
- Reset, then op = 00, lr = 1, num = 0x00F1, amt = 4, out_ready = 1 -> out_valid after exactly 4 cycles, shifted_num = 0x0F10, zero = 0.
- op = 01, lr = 0, num = 0x8001, amt = 3 -> shifted_num = 0xF000; num = 0x7FF0, amt = 4 -> shifted_num = 0x07FF.
- Back-to-back beats on 4 consecutive cycles: op = 10, lr = 0 (num = 0x1234, amt = 4) -> 0x4123; op = 10, lr = 1 (num = 0x8001, amt = 1) -> 0x0003; op = 11, amt = 7 (num = 0xBEEF) -> 0xBEEF; op = 00, lr = 0 (num = 0x0001, amt = 1) -> 0x0000 with zero = 1. Results appear on 4 consecutive cycles, in order.
- Backpressure: stream 6 beats, hold out_ready = 0 for 3 cycles once out_valid rises -> in_ready = 0 during the stall, shifted_num held stable, no beat lost or duplicated, order preserved.
- Assert n_rst low mid-stream with 3 beats in flight -> out_valid = 0 and shifted_num = 0 immediately (asynchronously). After release, no stale results; a new beat emerges 4 cycles after acceptance.
- Repeat the directed vectors with WIDTH = 8 and WIDTH = 32 against a reference model: latency = LOG_W, and correct fill for every op/lr/amt combination.
